// File: rtl/muldiv_pkg.sv
// Shared types and helpers for the iterative multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    PREP = 2'b01,
    RUN  = 2'b10,
    FIX  = 2'b11
  } muldiv_state_t;

  // Two's-complement magnitude; 0x8000_0000 maps to itself, read as unsigned.
  function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? (~x + 1'b1) : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg64(input logic [2*WIDTH-1:0] x);
    return ~x + 1'b1;
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Execute-stage request/response bundle for the mul/div unit.
interface muldiv_if;
  import muldiv_pkg::*;

  // start is taken only while busy=0 (busy acts as an inverted ready); done pulses
  // for one cycle once HI/LO hold the result. MT writes obey the same busy gate.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             mthi_en;
  logic             mtlo_en;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [1:0]       dbg_state;

  modport master (
    output start, op, op1, op2, mthi_en, mtlo_en, wdata,
    input  busy, done, hi, lo, dbg_state
  );

  modport slave (
    input  start, op, op1, op2, mthi_en, mtlo_en, wdata,
    output busy, done, hi, lo, dbg_state
  );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider owning the HI/LO pair.
module muldiv_unit
  import muldiv_pkg::*;
(
  input  logic clk,
  input  logic reset,
  muldiv_if.slave bus
);

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_PREP = PREP;
  localparam logic [1:0] S_RUN  = RUN;
  localparam logic [1:0] S_FIX  = FIX;

  logic [1:0]       r_state;
  logic [5:0]       r_cnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_m;
  logic [WIDTH-1:0] r_acc_hi;
  logic [WIDTH-1:0] r_acc_lo;
  logic             r_neg_q;
  logic             r_neg_r;
  logic             r_divz;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;
  logic             r_busy;
  logic             r_done;

  logic             w_is_div;
  logic             w_signed;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_msum;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH+1:0] w_diff;
  logic             w_fits;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0] w_q_fix;
  logic [WIDTH-1:0] w_r_fix;

  assign w_is_div = r_op[1];
  assign w_signed = ~r_op[0];
  assign w_a_mag  = w_signed ? abs_val(r_a) : r_a;
  assign w_b_mag  = w_signed ? abs_val(r_b) : r_b;

  // Multiply step: conditional add into acc_hi with carry, then the 65-bit shift.
  assign w_msum   = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_m} : {(WIDTH+1){1'b0}});

  // Divide step: the extra top bit of w_diff is the trial-subtract borrow.
  assign w_shift  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_diff   = {1'b0, w_shift} - {2'b00, r_m};
  assign w_fits   = ~w_diff[WIDTH+1];

  assign w_prod   = r_neg_q ? neg64({r_acc_hi, r_acc_lo}) : {r_acc_hi, r_acc_lo};
  assign w_q_fix  = r_neg_q ? (~r_acc_lo + 1'b1) : r_acc_lo;
  assign w_r_fix  = r_neg_r ? (~r_acc_hi + 1'b1) : r_acc_hi;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_acc_hi <= '0;
      r_acc_lo <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_divz   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!r_busy) begin
        if (bus.mthi_en) r_hi <= bus.wdata;
        if (bus.mtlo_en) r_lo <= bus.wdata;
      end
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_op    <= bus.op;
            r_a     <= bus.op1;
            r_b     <= bus.op2;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end
        end
        S_PREP: begin
          r_neg_q  <= w_signed & (r_a[WIDTH-1] ^ r_b[WIDTH-1]);
          r_neg_r  <= w_signed & r_a[WIDTH-1];
          r_divz   <= w_is_div & (r_b == '0);
          r_cnt    <= '0;
          r_acc_hi <= '0;
          r_m      <= w_is_div ? w_b_mag : w_a_mag;
          r_acc_lo <= w_is_div ? w_a_mag : w_b_mag;
          r_state  <= (w_is_div && (r_b == '0)) ? S_FIX : S_RUN;
        end
        S_RUN: begin
          if (w_is_div) begin
            r_acc_hi <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_fits};
          end else begin
            r_acc_hi <= w_msum[WIDTH:1];
            r_acc_lo <= {w_msum[0], r_acc_lo[WIDTH-1:1]};
          end
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'(WIDTH-1)) r_state <= S_FIX;
        end
        S_FIX: begin
          if (r_divz) begin
            r_hi <= r_a;
            r_lo <= '1;
          end else if (w_is_div) begin
            r_hi <= w_r_fix;
            r_lo <= w_q_fix;
          end else begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.hi        = r_hi;
  assign bus.lo        = r_lo;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit with an arithmetic reference model and per-cycle compare.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic cmp_en = 1'b0;
  int   n_vec  = 0;
  int   n_fail = 0;

  muldiv_if bus();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int          m_left   = 0;
  logic [31:0] m_hi     = '0;
  logic [31:0] m_lo     = '0;
  logic [31:0] m_res_hi = '0;
  logic [31:0] m_res_lo = '0;
  logic        m_done   = 1'b0;

  function automatic void model_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic signed [63:0] sa, sb, p, q, r;
    logic [63:0] u;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    dz = 1'b0;
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      2'b01: begin u = {32'b0, a} * {32'b0, b}; hi = u[63:32]; lo = u[31:0]; end
      default: begin
        if (b == 32'd0) begin
          dz = 1'b1; hi = a; lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          q = sa / sb; r = sa % sb; hi = r[31:0]; lo = q[31:0];
        end else begin
          hi = a % b; lo = a / b;
        end
      end
    endcase
  endfunction

  always @(posedge clk or posedge reset) begin
    logic dz;
    if (reset) begin
      m_left = 0; m_hi = '0; m_lo = '0; m_done = 1'b0;
    end else begin
      m_done = 1'b0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = m_res_hi; m_lo = m_res_lo; m_done = 1'b1;
        end
      end else begin
        if (bus.mthi_en) m_hi = bus.wdata;
        if (bus.mtlo_en) m_lo = bus.wdata;
        if (bus.start) begin
          model_op(bus.op, bus.op1, bus.op2, m_res_hi, m_res_lo, dz);
          m_left = dz ? 2 : 34;
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("cyc_busy", {31'b0, bus.busy}, {31'b0, (m_left > 0)});
      check("cyc_done", {31'b0, bus.done}, {31'b0, m_done});
      check("cyc_hi", bus.hi, m_hi);
      check("cyc_lo", bus.lo, m_lo);
    end
  end

  // ---------------- drivers ----------------
  task automatic pulse_inputs(input logic st, input logic [1:0] op, input logic [31:0] a,
                              input logic [31:0] b, input logic hen, input logic len,
                              input logic [31:0] wd);
    #2;
    bus.start = st; bus.op = op; bus.op1 = a; bus.op2 = b;
    bus.mthi_en = hen; bus.mtlo_en = len; bus.wdata = wd;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    bit found = 1'b0;
    lat = 0;
    busy_cnt = 0;
    for (int cyc = 1; cyc <= 100 && !found; cyc++) begin
      @(negedge clk);
      if (bus.busy) busy_cnt++;
      if (bus.done) begin found = 1'b1; lat = cyc; end
    end
    check("done_seen", {31'b0, found}, 32'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                        input int elat);
    int lat, bc;
    pulse_inputs(1'b1, op, a, b, 1'b0, 1'b0, 32'd0);
    wait_done(lat, bc);
    check({name, "_lat"}, 32'(lat), 32'(elat));
    check({name, "_busy"}, 32'(bc), 32'(elat - 1));
    check({name, "_hi"}, bus.hi, ehi);
    check({name, "_lo"}, bus.lo, elo);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, bc, dcount;
    bus.start = 1'b0; bus.op = 2'b00; bus.op1 = '0; bus.op2 = '0;
    bus.mthi_en = 1'b0; bus.mtlo_en = 1'b0; bus.wdata = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    check("rst_hi", bus.hi, 32'd0);
    check("rst_lo", bus.lo, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_state", {30'b0, bus.dbg_state}, 32'd0);
    cmp_en = 1'b1;

    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 35);
    run_op("mult_m3x7", OP_MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 35);
    run_op("mult_min2", OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 35);
    run_op("div_m7d2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 35);
    run_op("divu_7d2",  OP_DIVU,  32'd7,         32'd2,         32'd1,         32'd3,         35);
    run_op("div_minm1", OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 35);
    run_op("div_100m7", OP_DIV,   32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, 35);
    run_op("divu_5d0",  OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 3);
    run_op("div_m7d0",  OP_DIV,   32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, 3);

    // Start and MTHI while busy must both be dropped.
    pulse_inputs(1'b1, OP_MULTU, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b0, 32'd0);
    repeat (6) @(negedge clk);
    pulse_inputs(1'b1, OP_MULTU, 32'd2, 32'd2, 1'b1, 1'b0, 32'h1234);
    wait_done(lat, bc);
    check("intf_hi", bus.hi, 32'd1);
    check("intf_lo", bus.lo, 32'd0);
    @(negedge clk);
    check("intf_idle", {31'b0, bus.busy}, 32'd0);

    pulse_inputs(1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b1, 32'hABCD);
    @(negedge clk);
    check("mtlo_lo", bus.lo, 32'h0000_ABCD);
    check("mtlo_hi", bus.hi, 32'd1);

    // MTHI together with start: the write lands now, the result overwrites it later.
    pulse_inputs(1'b1, OP_DIVU, 32'd7, 32'd2, 1'b1, 1'b0, 32'h55);
    @(negedge clk);
    check("mtst_hi_now", bus.hi, 32'h55);
    wait_done(lat, bc);
    check("mtst_hi_end", bus.hi, 32'd1);
    check("mtst_lo_end", bus.lo, 32'd3);

    pulse_inputs(1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b1, 32'h77);
    @(negedge clk);
    check("mtboth_hi", bus.hi, 32'h77);
    check("mtboth_lo", bus.lo, 32'h77);

    // Reset in the middle of a divide.
    pulse_inputs(1'b1, OP_DIV, 32'h1234_5678, 32'd3, 1'b0, 1'b0, 32'd0);
    repeat (11) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mrst_busy", {31'b0, bus.busy}, 32'd0);
    check("mrst_hi", bus.hi, 32'd0);
    check("mrst_lo", bus.lo, 32'd0);
    check("mrst_done", {31'b0, bus.done}, 32'd0);
    @(negedge clk);
    #2 reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dcount++;
    end
    check("mrst_nodone", 32'(dcount), 32'd0);

    run_op("multu_3x4", OP_MULTU, 32'd3, 32'd4, 32'd0, 32'd12, 35);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative multiply/divide sequencer owning the architectural HI/LO register pair. Accepts MULT, MULTU, DIV and DIVU requests from the execute stage and runs a 32-iteration shift-add multiply or restoring divide. Raises `busy` so the pipeline stalls MFHI/MFLO and further mul/div issue, then writes HI/LO. Also services MTHI/MTLO writes and sits beside the single-cycle ALU in the execute stage.

## Interface
- `WIDTH`, 32, operand and HI/LO width; the iteration count equals `WIDTH`.
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request an operation; sampled only while `busy`=0.
- `op`  in  2  operation code: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `op1`  in  WIDTH  rs operand (multiplicand / dividend); sampled with `start`.
- `op2`  in  WIDTH  rt operand (multiplier / divisor); sampled with `start`.
- `mthi_en`  in  1  write `wdata` to HI.
- `mtlo_en`  in  1  write `wdata` to LO.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  operation in flight; the pipeline must stall MFHI/MFLO and mul/div issue.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result.
- `hi`  out  WIDTH  HI register: product[63:32] or remainder.
- `lo`  out  WIDTH  LO register: product[31:0] or quotient.

## Operation
- States: IDLE, PREP, RUN, FIX.
  - IDLE→PREP on `start`.
  - PREP→RUN normally; PREP→FIX directly on a DIV/DIVU with `op2`=0.
  - RUN→FIX after 32 iterations.
  - FIX→IDLE always.
- PREP:
  - For MULT/DIV, replace operands with magnitudes. Magnitude of 0x8000_0000 is 0x8000_0000 as an unsigned value.
  - Record `neg_q`: operand signs differ.
  - Record `neg_r`: dividend negative.
  - MULTU/DIVU: operands unchanged, both flags 0.
  - Clear the 6-bit iteration counter.
- RUN multiply (64-bit accumulator {acc_hi, acc_lo}, multiplier loaded into acc_lo):
  - If acc_lo[0]=1, add the multiplicand to acc_hi with a 33-bit carry.
  - Then shift the 65-bit value right by 1.
- RUN divide (33-bit partial remainder, quotient in acc_lo):
  - Shift {rem, quotient} left by 1.
  - Trial-subtract the divisor; if the result is non-negative, keep it and set quotient bit 0.
- FIX:
  - Multiply: negate the full 64-bit product if `neg_q`.
  - Divide: negate the quotient if `neg_q`; negate the remainder if `neg_r`.
  - Write HI/LO; assert `done` on the following cycle.
- Divide by zero (both DIV and DIVU): HI=`op1` unmodified, LO=0xFFFF_FFFF.
- DIV 0x8000_0000 / 0xFFFF_FFFF: natural result LO=0x8000_0000, HI=0; no trap.
- MTHI/MTLO:
  - Take effect at the edge they are sampled, only while `busy`=0.
  - Ignored while `busy`=1.
  - Both may write in the same cycle.
  - If asserted together with `start`, both act: the MT write lands now, and the operation result overwrites it at completion.
- `start` while `busy`=1 is ignored; no queueing.

## Timing
- `start` sampled at edge N:
  - `busy`=1 for cycles N+1 … N+34 (34 cycles).
  - HI/LO update at edge N+34.
  - `done`=1 for exactly one cycle after edge N+34, with `busy`=0 in that same cycle.
- Divide by zero: `busy` high 2 cycles, HI/LO written at edge N+2, `done` after N+2.
- A new `start` is accepted in the same cycle `done` is high.
- All outputs are registered.
- HI/LO hold their value throughout RUN. Partial results live in internal accumulators only.
- Reset values, asynchronous and applied at any time including mid-RUN:
  - state IDLE, counter 0, accumulators 0.
  - `hi`=0, `lo`=0, `busy`=0, `done`=0.
  - An in-flight operation is discarded with no `done`.

## Structure
- Package `muldiv_pkg` holds:
  - `WIDTH` default constant.
  - `muldiv_op_t` enum (MULT/MULTU/DIV/DIVU).
  - `muldiv_state_t` enum (IDLE/PREP/RUN/FIX).
  - Pure functions `abs_val` and `neg64`.
- Single module with no sub-module. The FSM and the shared accumulator datapath are too tightly coupled to split usefully.

## Test plan
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → HI=0xFFFF_FFFE, LO=0x0000_0001; `done` exactly 35 cycles after the `start` edge; `busy` high 34 cycles.
- MULT −3 × 7 → HI=0xFFFF_FFFF, LO=0xFFFF_FFEB. MULT 0x8000_0000 × 0x8000_0000 → HI=0x4000_0000, LO=0.
- DIV −7 / 2 → LO=0xFFFF_FFFD, HI=0xFFFF_FFFF. DIVU 7 / 2 → LO=3, HI=1. DIV 0x8000_0000 / −1 → LO=0x8000_0000, HI=0.
- DIVU 5 / 0 → HI=5, LO=0xFFFF_FFFF; `busy` high 2 cycles.
- During RUN, pulse `start` with MULTU 2×2 and `mthi_en` with `wdata`=0x1234 → both ignored; the original result is unaffected. After completion, `mtlo_en` with 0xABCD → LO=0xABCD next cycle.
- Assert `reset` at iteration 10 of a DIV → immediately `busy`=0, HI=LO=0, no `done`. A following MULTU 3×4 completes normally with LO=12, HI=0.
